// File: rtl/id_stage.sv
// MIPS32 instruction decode stage: decodes the logic/shift subset, resolves
// operands from the register file with execute/memory bypass, and holds the
// result in a ready/valid issue register for the execute stage.
module id_stage (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_valid_i,
  input  logic [31:0] inst_i,
  output logic        inst_ready_o,
  input  logic        flush_i,

  output logic        re1_o,
  output logic [4:0]  raddr1_o,
  output logic        re2_o,
  output logic [4:0]  raddr2_o,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,

  input  logic        fwd_ex_wreg_i,
  input  logic [4:0]  fwd_ex_wd_i,
  input  logic [31:0] fwd_ex_wdata_i,
  input  logic        fwd_mem_wreg_i,
  input  logic [4:0]  fwd_mem_wd_i,
  input  logic [31:0] fwd_mem_wdata_i,

  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  aluop_o,
  output logic [2:0]  alusel_o,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,

  output logic        illegal_o,
  output logic [15:0] illegal_cnt_o
);

  // ALU operation codes
  localparam logic [7:0] ALUOP_NOP = 8'h00;
  localparam logic [7:0] ALUOP_AND = 8'h24;
  localparam logic [7:0] ALUOP_OR  = 8'h25;
  localparam logic [7:0] ALUOP_XOR = 8'h26;
  localparam logic [7:0] ALUOP_NOR = 8'h27;
  localparam logic [7:0] ALUOP_SLL = 8'h7C;
  localparam logic [7:0] ALUOP_SRL = 8'h02;
  localparam logic [7:0] ALUOP_SRA = 8'h03;

  // ALU result selectors
  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT = 3'b010;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  // SPECIAL function codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm   = inst_i[15:0];

  // Read addresses always follow the rs/rt fields; only the enables vary
  assign raddr1_o = rs;
  assign raddr2_o = rt;

  // Resolved operand for one read port: $0 reads zero, then the youngest
  // in-flight result wins over the register file.
  function automatic logic [31:0] resolve(
    input logic [4:0]  addr,
    input logic [31:0] rdata,
    input logic        ex_wreg,
    input logic [4:0]  ex_wd,
    input logic [31:0] ex_wdata,
    input logic        mem_wreg,
    input logic [4:0]  mem_wd,
    input logic [31:0] mem_wdata
  );
    logic [31:0] val;
    if (addr == 5'd0)
      val = '0;
    else if (ex_wreg && (ex_wd == addr))
      val = ex_wdata;
    else if (mem_wreg && (mem_wd == addr))
      val = mem_wdata;
    else
      val = rdata;
    return val;
  endfunction

  logic [31:0] port1_val;
  logic [31:0] port2_val;

  // Operand resolution is independent of the read enables so decode can pick
  // whichever port it needs without a combinational loop through re1/re2.
  always_comb begin
    port1_val = resolve(rs, rdata1_i, fwd_ex_wreg_i, fwd_ex_wd_i, fwd_ex_wdata_i,
                        fwd_mem_wreg_i, fwd_mem_wd_i, fwd_mem_wdata_i);
    port2_val = resolve(rt, rdata2_i, fwd_ex_wreg_i, fwd_ex_wd_i, fwd_ex_wdata_i,
                        fwd_mem_wreg_i, fwd_mem_wd_i, fwd_mem_wdata_i);
  end

  logic [7:0]  dec_aluop;
  logic [2:0]  dec_alusel;
  logic [31:0] dec_reg1;
  logic [31:0] dec_reg2;
  logic [4:0]  dec_wd;
  logic        dec_wreg;
  logic        dec_illegal;
  logic        dec_re1;
  logic        dec_re2;

  // Instruction decode; anything unmatched falls through as an illegal NOP
  always_comb begin
    dec_aluop   = ALUOP_NOP;
    dec_alusel  = ALUSEL_NOP;
    dec_reg1    = '0;
    dec_reg2    = '0;
    dec_wd      = '0;
    dec_wreg    = 1'b0;
    dec_illegal = 1'b1;
    dec_re1     = 1'b0;
    dec_re2     = 1'b0;

    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_AND, F_OR, F_XOR, F_NOR: begin
            case (funct)
              F_AND:   dec_aluop = ALUOP_AND;
              F_OR:    dec_aluop = ALUOP_OR;
              F_XOR:   dec_aluop = ALUOP_XOR;
              default: dec_aluop = ALUOP_NOR;
            endcase
            dec_alusel  = ALUSEL_LOGIC;
            dec_re1     = 1'b1;
            dec_re2     = 1'b1;
            dec_reg1    = port1_val;
            dec_reg2    = port2_val;
            dec_wd      = rd;
            dec_wreg    = 1'b1;
            dec_illegal = 1'b0;
          end
          F_SLL, F_SRL, F_SRA: begin
            if (rs == 5'd0) begin
              case (funct)
                F_SLL:   dec_aluop = ALUOP_SLL;
                F_SRL:   dec_aluop = ALUOP_SRL;
                default: dec_aluop = ALUOP_SRA;
              endcase
              dec_alusel  = ALUSEL_SHIFT;
              dec_re2     = 1'b1;
              dec_reg1    = port2_val;
              dec_reg2    = {27'b0, sa};
              dec_wd      = rd;
              dec_wreg    = 1'b1;
              dec_illegal = 1'b0;
            end
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            if (sa == 5'd0) begin
              case (funct)
                F_SLLV:  dec_aluop = ALUOP_SLL;
                F_SRLV:  dec_aluop = ALUOP_SRL;
                default: dec_aluop = ALUOP_SRA;
              endcase
              // Shift value comes from rt, shift amount from rs
              dec_alusel  = ALUSEL_SHIFT;
              dec_re1     = 1'b1;
              dec_re2     = 1'b1;
              dec_reg1    = port2_val;
              dec_reg2    = port1_val;
              dec_wd      = rd;
              dec_wreg    = 1'b1;
              dec_illegal = 1'b0;
            end
          end
          default: ;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        case (op)
          OP_ANDI: dec_aluop = ALUOP_AND;
          OP_ORI:  dec_aluop = ALUOP_OR;
          default: dec_aluop = ALUOP_XOR;
        endcase
        dec_alusel  = ALUSEL_LOGIC;
        dec_re1     = 1'b1;
        dec_reg1    = port1_val;
        dec_reg2    = {16'b0, imm};
        dec_wd      = rt;
        dec_wreg    = 1'b1;
        dec_illegal = 1'b0;
      end
      OP_LUI: begin
        if (rs == 5'd0) begin
          dec_aluop   = ALUOP_OR;
          dec_alusel  = ALUSEL_LOGIC;
          dec_reg2    = {imm, 16'b0};
          dec_wd      = rt;
          dec_wreg    = 1'b1;
          dec_illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign re1_o = dec_re1;
  assign re2_o = dec_re2;

  logic        valid_q;
  logic [7:0]  aluop_q;
  logic [2:0]  alusel_q;
  logic [31:0] reg1_q;
  logic [31:0] reg2_q;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic        illegal_q;
  logic [15:0] cnt_q;
  logic        accept;

  assign inst_ready_o = !valid_q || out_ready_i;
  assign accept       = inst_valid_i && inst_ready_o && !flush_i;

  // Issue register: reset > flush > accept > drain; payload only moves on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      aluop_q   <= ALUOP_NOP;
      alusel_q  <= ALUSEL_NOP;
      reg1_q    <= '0;
      reg2_q    <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else if (flush_i) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      aluop_q   <= dec_aluop;
      alusel_q  <= dec_alusel;
      reg1_q    <= dec_reg1;
      reg2_q    <= dec_reg2;
      wd_q      <= dec_wd;
      wreg_q    <= dec_wreg;
      illegal_q <= dec_illegal;
      if (dec_illegal && (cnt_q != 16'hFFFF))
        cnt_q <= cnt_q + 16'd1;
    end else begin
      if (out_ready_i)
        valid_q <= 1'b0;
      illegal_q <= 1'b0;
    end
  end

  assign out_valid_o   = valid_q;
  assign aluop_o       = aluop_q;
  assign alusel_o      = alusel_q;
  assign reg1_o        = reg1_q;
  assign reg2_o        = reg2_q;
  assign wd_o          = wd_q;
  assign wreg_o        = wreg_q && valid_q;
  assign illegal_o     = illegal_q;
  assign illegal_cnt_o = cnt_q;

endmodule
